// File: rtl/command_credit_gate.sv
// Command FIFO between the work element and the PSL command port. Commands are
// issued only while PSL credits remain; credits are loaded from croom and replenished by responses.
module command_credit_gate #(
    parameter int FIFO_DEPTH   = 4,
    parameter int CREDIT_WIDTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enabled,
    input  logic [CREDIT_WIDTH-1:0] initial_credits,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [12:0]             in_command,
    input  logic [7:0]              in_tag,
    input  logic [11:0]             in_size,
    input  logic [63:0]             in_address,
    output logic                    out_valid,
    output logic [12:0]             out_command,
    output logic [7:0]              out_tag,
    output logic [11:0]             out_size,
    output logic [63:0]             out_address,
    output logic                    out_command_parity,
    output logic                    out_tag_parity,
    output logic                    out_address_parity,
    output logic [2:0]              out_abt,
    output logic [15:0]             out_context_handle,
    input  logic                    response_valid,
    input  logic [8:0]              response_credits,
    output logic [CREDIT_WIDTH-1:0] credits,
    output logic                    credit_error
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = 13 + 8 + 12 + 64;
    localparam int NW      = CREDIT_WIDTH + 2;

    logic [ENTRY_W-1:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]          rd_ptr_q, rd_ptr_d;
    logic                    enabled_q, enabled_d;
    logic [CREDIT_WIDTH-1:0] credits_q, credits_d;
    logic [CREDIT_WIDTH-1:0] credit_max_q, credit_max_d;
    logic                    credit_error_q, credit_error_d;
    logic                    out_valid_q, out_valid_d;
    logic [ENTRY_W-1:0]      out_entry_q, out_entry_d;

    logic                    full, empty, push, issue, load;
    logic signed [NW-1:0]    resp_ext, credit_next;

    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign in_ready = enabled && !full;
    assign push     = in_valid && in_ready;
    assign load     = enabled && !enabled_q;
    assign issue    = enabled && enabled_q && !empty && (credits_q != '0);

    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        enabled_d      = enabled;
        credits_d      = credits_q;
        credit_max_d   = credit_max_q;
        credit_error_d = credit_error_q;
        out_valid_d    = 1'b0;
        out_entry_d    = out_entry_q;
        resp_ext       = response_valid ?
                         {{(NW-9){response_credits[8]}}, response_credits} : '0;
        // Wide enough that neither the largest return nor a full underflow can wrap.
        credit_next    = $signed({2'b00, credits_q}) - (issue ? NW'(1) : NW'(0)) + resp_ext;

        if (!enabled) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            credits_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
            end
            if (issue) begin
                rd_ptr_d    = rd_ptr_q + (PTR_W+1)'(1);
                out_valid_d = 1'b1;
                out_entry_d = mem_q[rd_ptr_q[PTR_W-1:0]];
            end
            if (load) begin
                credits_d    = initial_credits;
                credit_max_d = initial_credits;
            end else if (credit_next[NW-1]) begin
                credits_d      = '0;
                credit_error_d = 1'b1;
            end else if (credit_next > $signed({2'b00, credit_max_q})) begin
                credits_d      = credit_max_q;
                credit_error_d = 1'b1;
            end else begin
                credits_d = credit_next[CREDIT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= {in_command, in_tag, in_size, in_address};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            enabled_q      <= 1'b0;
            credits_q      <= '0;
            credit_max_q   <= '0;
            credit_error_q <= 1'b0;
            out_valid_q    <= 1'b0;
            out_entry_q    <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            enabled_q      <= enabled_d;
            credits_q      <= credits_d;
            credit_max_q   <= credit_max_d;
            credit_error_q <= credit_error_d;
            out_valid_q    <= out_valid_d;
            out_entry_q    <= out_entry_d;
        end
    end

    assign out_valid = out_valid_q;
    assign {out_command, out_tag, out_size, out_address} = out_entry_q;
    assign out_command_parity = ~^out_command;
    assign out_tag_parity     = ~^out_tag;
    assign out_address_parity = ~^out_address;
    assign out_abt            = '0;
    assign out_context_handle = '0;
    assign credits            = credits_q;
    assign credit_error       = credit_error_q;

endmodule

// File: tb/tb_command_credit_gate.sv
// Bench for command_credit_gate: queue/integer reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_command_credit_gate;

    localparam int DEPTH = 4;
    localparam int CW    = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          enabled;
    logic [CW-1:0] initial_credits;
    logic          in_valid, in_ready;
    logic [12:0]   in_command;
    logic [7:0]    in_tag;
    logic [11:0]   in_size;
    logic [63:0]   in_address;
    logic          out_valid;
    logic [12:0]   out_command;
    logic [7:0]    out_tag;
    logic [11:0]   out_size;
    logic [63:0]   out_address;
    logic          out_command_parity, out_tag_parity, out_address_parity;
    logic [2:0]    out_abt;
    logic [15:0]   out_context_handle;
    logic          response_valid;
    logic [8:0]    response_credits;
    logic [CW-1:0] credits;
    logic          credit_error;

    command_credit_gate #(.FIFO_DEPTH(DEPTH), .CREDIT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset), .enabled(enabled), .initial_credits(initial_credits),
        .in_valid(in_valid), .in_ready(in_ready), .in_command(in_command), .in_tag(in_tag),
        .in_size(in_size), .in_address(in_address), .out_valid(out_valid),
        .out_command(out_command), .out_tag(out_tag), .out_size(out_size),
        .out_address(out_address), .out_command_parity(out_command_parity),
        .out_tag_parity(out_tag_parity), .out_address_parity(out_address_parity),
        .out_abt(out_abt), .out_context_handle(out_context_handle),
        .response_valid(response_valid), .response_credits(response_credits),
        .credits(credits), .credit_error(credit_error)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b1;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue for the FIFO and plain integers for credits.
    logic [96:0] mq[$];
    logic [96:0] m_out = '0;
    int  m_cred = 0, m_max = 0, m_n = 0, m_r = 0;
    bit  m_err = 0, m_enq = 0, m_ov = 0, m_iss = 0, m_psh = 0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_cred = 0; m_max = 0; m_err = 0; m_enq = 0; m_ov = 0; m_out = '0;
        end else begin
            m_psh = enabled && in_valid && (mq.size() < DEPTH);
            m_iss = enabled && m_enq && (mq.size() > 0) && (m_cred != 0);
            if (!enabled) begin
                mq.delete();
                m_cred = 0; m_ov = 0; m_enq = 0;
            end else begin
                m_ov = m_iss;
                if (m_iss) m_out = mq.pop_front();
                if (m_psh) mq.push_back({in_command, in_tag, in_size, in_address});
                if (!m_enq) begin
                    m_cred = int'(initial_credits);
                    m_max  = int'(initial_credits);
                end else begin
                    m_r = 0;
                    if (response_valid)
                        m_r = response_credits[8] ? int'(response_credits) - 512 : int'(response_credits);
                    m_n = m_cred - (m_iss ? 1 : 0) + m_r;
                    if (m_n > m_max) begin m_cred = m_max; m_err = 1; end
                    else if (m_n < 0) begin m_cred = 0; m_err = 1; end
                    else m_cred = m_n;
                end
                m_enq = 1;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_on) begin
            check("out_valid",   out_valid,   m_ov);
            check("out_command", out_command, m_out[96:84]);
            check("out_tag",     out_tag,     m_out[83:76]);
            check("out_size",    out_size,    m_out[75:64]);
            check("out_address", out_address, m_out[63:0]);
            check("cmd_parity",  out_command_parity, ~^m_out[96:84]);
            check("tag_parity",  out_tag_parity,     ~^m_out[83:76]);
            check("addr_parity", out_address_parity, ~^m_out[63:0]);
            check("abt",         out_abt, 3'd0);
            check("ctx_handle",  out_context_handle, 16'd0);
            check("credits",     credits, CW'(m_cred));
            check("credit_error", credit_error, m_err);
            check("in_ready",    in_ready, enabled && (mq.size() < DEPTH));
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #2;
        end
    endtask

    task automatic set_cmd(input logic [7:0] tag, input logic [63:0] addr);
        in_command = 13'h0A00;
        in_tag     = tag;
        in_size    = 12'd128;
        in_address = addr;
    endtask

    int   ngot;
    logic [7:0] got [8];
    bit   acc;

    initial begin
        reset = 1'b0; enabled = 1'b0; initial_credits = '0; in_valid = 1'b0;
        in_command = '0; in_tag = '0; in_size = '0; in_address = '0;
        response_valid = 1'b0; response_credits = '0;
        cyc(2);
        check("rst_credits", credits, 0);
        check("rst_error", credit_error, 0);
        check("rst_valid", out_valid, 0);
        check("rst_cmd_par", out_command_parity, 1);
        check("rst_tag_par", out_tag_parity, 1);
        check("rst_addr_par", out_address_parity, 1);
        check("rst_in_ready", in_ready, 0);
        reset = 1'b1;
        cyc(1);

        // Basic issue: accepted at edge t, visible after edge t+1.
        enabled = 1'b1; initial_credits = 8'd2;
        cyc(1);
        set_cmd(8'd1, 64'h1000); in_valid = 1'b1;
        cyc(1);
        in_valid = 1'b0;
        check("basic_not_early", out_valid, 0);
        cyc(1);
        check("basic_valid", out_valid, 1);
        check("basic_tag", out_tag, 8'd1);
        check("basic_addr", out_address, 64'h1000);
        check("basic_credits", credits, 8'd1);
        check("basic_tag_par", out_tag_parity, 0);
        cyc(1);
        check("basic_strobe", out_valid, 0);

        // Credit stall with a single credit.
        enabled = 1'b0; cyc(1);
        enabled = 1'b1; initial_credits = 8'd1; cyc(1);
        in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            set_cmd(8'(i), 64'(i) << 12);
            cyc(1);
        end
        in_valid = 1'b0;
        cyc(2);
        check("stall_credits", credits, 8'd0);
        check("stall_tag", out_tag, 8'd1);
        response_valid = 1'b1; response_credits = 9'd1;
        cyc(1);
        response_valid = 1'b0;
        check("stall_ret_credits", credits, 8'd1);
        cyc(1);
        check("stall_valid2", out_valid, 1);
        check("stall_tag2", out_tag, 8'd2);
        check("stall_credits2", credits, 8'd0);
        cyc(2);
        check("stall_tag3_waits", out_tag, 8'd2);

        // FIFO full: drain credits, fill, then release four credits.
        enabled = 1'b0; cyc(1);
        enabled = 1'b1; initial_credits = 8'd4; cyc(1);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_cmd(8'h10 + 8'(i), 64'h2000);
            cyc(1);
        end
        in_valid = 1'b0;
        cyc(3);
        check("full_drained", credits, 8'd0);
        in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            set_cmd(8'(i), 64'h3000 + 64'(i));
            cyc(1);
        end
        set_cmd(8'd5, 64'h3005);
        check("full_ready_low", in_ready, 0);
        cyc(2);
        check("full_ready_held", in_ready, 0);
        response_valid = 1'b1; response_credits = 9'd4;
        acc = 1'b0;
        cyc(1);
        response_valid = 1'b0;
        ngot = 0;
        for (int i = 0; i < 8; i++) begin
            acc = in_valid && in_ready;
            cyc(1);
            if (acc) in_valid = 1'b0;
            if (out_valid && ngot < 8) begin
                got[ngot] = out_tag;
                ngot++;
            end
        end
        in_valid = 1'b0;
        check("full_issue_count", ngot, 4);
        for (int i = 0; i < 4; i++) check("full_order", got[i], 8'(i + 1));
        check("full_credits", credits, 8'd0);

        // Tag 5 is queued: add one credit, then issue with a same-cycle return.
        response_valid = 1'b1; response_credits = 9'd1;
        cyc(1);
        check("sim_pre_credits", credits, 8'd1);
        check("sim_pre_valid", out_valid, 0);
        cyc(1);
        response_valid = 1'b0;
        check("sim_valid", out_valid, 1);
        check("sim_tag", out_tag, 8'd5);
        check("sim_credits", credits, 8'd1);

        // Overflow clamps to croom and is sticky through an enabled toggle.
        enabled = 1'b0; cyc(1);
        enabled = 1'b1; initial_credits = 8'd3; cyc(1);
        response_valid = 1'b1; response_credits = 9'd2;
        cyc(1);
        response_valid = 1'b0;
        check("ovf_credits", credits, 8'd3);
        check("ovf_error", credit_error, 1);
        enabled = 1'b0; cyc(1);
        enabled = 1'b1; initial_credits = 8'd0; cyc(2);
        check("ovf_sticky", credit_error, 1);
        reset = 1'b0; enabled = 1'b0; cyc(1);
        reset = 1'b1;
        check("err_cleared", credit_error, 0);
        enabled = 1'b1; cyc(1);
        response_valid = 1'b1; response_credits = 9'h1FF;
        cyc(1);
        response_valid = 1'b0;
        check("udf_credits", credits, 8'd0);
        check("udf_error", credit_error, 1);

        // Abort with commands queued; nothing stale issues after re-enable.
        in_valid = 1'b1;
        for (int i = 7; i <= 9; i++) begin
            set_cmd(8'(i), 64'h4000);
            cyc(1);
        end
        in_valid = 1'b0;
        cyc(1);
        enabled = 1'b0; cyc(1);
        check("abort_ready", in_ready, 0);
        check("abort_credits", credits, 8'd0);
        enabled = 1'b1; initial_credits = 8'd4; cyc(1);
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            check("abort_no_stale", out_valid, 0);
        end
        check("abort_reload", credits, 8'd4);
        set_cmd(8'h2A, 64'h5000); in_valid = 1'b1;
        cyc(1);
        in_valid = 1'b0;
        cyc(1);
        check("rst_issue_valid", out_valid, 1);
        #1 reset = 1'b0; enabled = 1'b0;
        #1 check("rst_abort_valid", out_valid, 0);
        check("rst_abort_credits", credits, 8'd0);
        cyc(1);
        reset = 1'b1;
        cyc(1);

        // Randomized traffic.
        enabled = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) enabled = ~enabled;
            initial_credits  = 8'($urandom_range(0, 6));
            in_valid         = ($urandom_range(0, 9) < 6);
            in_command       = 13'($urandom);
            in_tag           = 8'($urandom);
            in_size          = 12'($urandom);
            in_address       = {$urandom, $urandom};
            response_valid   = ($urandom_range(0, 9) < 3);
            response_credits = ($urandom_range(0, 19) == 0) ? 9'($urandom) : 9'($urandom_range(0, 2));
            if (i % 400 == 399) begin
                reset = 1'b0;
                cyc(1);
                reset = 1'b1;
            end
            cyc(1);
        end
        in_valid = 1'b0; response_valid = 1'b0;
        cyc(2);
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
